// File: rtl/uart_tx_path.sv
// UART transmitter: frames a parallel word as start/data/[parity]/stop bits,
// timed by an external oversample enable (baud_tick).
module uart_tx_path #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // state  | meaning
  // IDLE   | line high, waiting for tx_start
  // START  | driving the start bit (0)
  // DATA   | driving data bits LSB first
  // PARITY | driving the latched parity bit
  // STOP   | driving stop bit(s) (1)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_t               state, state_nxt;
  logic [3:0]           tick_cnt, tick_nxt;
  logic [2:0]           bit_cnt, bit_nxt;
  logic                 stop_cnt, stop_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 parity, parity_nxt;
  logic                 serial_nxt, busy_nxt, done_nxt;
  logic                 bit_end;

  assign bit_end = baud_tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift     <= '0;
      parity    <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      stop_cnt  <= stop_nxt;
      shift     <= shift_nxt;
      parity    <= parity_nxt;
      tx_serial <= serial_nxt;
      tx_busy   <= busy_nxt;
      tx_done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (tx_start) state_nxt = START;
      START:  if (bit_end) state_nxt = DATA;
      DATA:   if (bit_end && bit_cnt == BIT_LAST)
                state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end && stop_cnt == STOP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tick_nxt   = tick_cnt;
    bit_nxt    = '0;
    stop_nxt   = 1'b0;
    shift_nxt  = shift;
    parity_nxt = parity;
    serial_nxt = 1'b1;

    // Any bit boundary or state change restarts the oversample count.
    if (state == IDLE || state_nxt != state || bit_end)
      tick_nxt = '0;
    else if (baud_tick)
      tick_nxt = tick_cnt + 4'd1;

    if (state == DATA) begin
      if (!bit_end)                  bit_nxt = bit_cnt;
      else if (bit_cnt != BIT_LAST)  bit_nxt = bit_cnt + 3'd1;
    end
    if (state == STOP) begin
      if (!bit_end)                  stop_nxt = stop_cnt;
      else if (stop_cnt != STOP_LAST) stop_nxt = 1'b1;
    end

    if (state == IDLE && tx_start) begin
      shift_nxt  = tx_data;
      parity_nxt = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
    end else if (state == DATA && bit_end) begin
      shift_nxt = shift >> 1;
    end

    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shift_nxt[0];
      PARITY:  serial_nxt = parity;
      default: serial_nxt = 1'b1;
    endcase

    busy_nxt = (state_nxt == START) || (state_nxt == DATA) ||
               (state_nxt == PARITY) || (state_nxt == STOP);
    done_nxt = (state == STOP) && (state_nxt == IDLE);
  end

endmodule
